// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared mode encoding for the counter control front-end
package counter_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2
  } mode_t;

  // Mode button cycles IDLE -> UP -> DOWN -> IDLE; any stray code returns to IDLE.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_IDLE: return MODE_UP;
      MODE_UP:   return MODE_DOWN;
      default:   return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - control bundle from the front-end to the up/down counter
interface counter_ctrl_if #(
  parameter int N = 64
);
  logic         load;
  logic         enable;
  logic         dec;
  logic [N-1:0] load_value;

  modport master (output load, enable, dec, load_value);
  modport slave  (input  load, enable, dec, load_value);
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, debounce counter and press detector for one raw button
module button_debouncer #(
  parameter int DB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level = db_q;
  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/counter_ctrl_frontend.sv
// rtl/counter_ctrl_frontend.sv - button-driven mode FSM and strobe generator for the up/down counter
module counter_ctrl_frontend
  import counter_ctrl_pkg::*;
#(
  parameter int N         = 64,
  parameter int DB_CYCLES = 16,
  parameter int TICK_DIV  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_load,
  input  logic [N-1:0]      sw_value,
  counter_ctrl_if.master    ctrl,
  output logic [MODE_W-1:0] mode
);

  localparam int TW = $clog2(TICK_DIV) + 1;

  logic mode_press, load_press;
  logic mode_level, load_level, unused_levels;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clock (clock),
    .reset (reset),
    .raw   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clock (clock),
    .reset (reset),
    .raw   (btn_load),
    .level (load_level),
    .press (load_press)
  );

  assign unused_levels = mode_level ^ load_level;

  mode_t         mode_q, mode_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          load_q, load_d;
  logic          enable_q, enable_d;
  logic          dec_q, dec_d;
  logic [N-1:0]  load_value_q, load_value_d;

  always_comb begin
    mode_d       = mode_q;
    tick_d       = '0;
    load_d       = load_press;
    load_value_d = load_value_q;
    if (mode_press) begin
      mode_d = next_mode(mode_q);
    end
    if (load_press) begin
      load_value_d = sw_value;
    end
    // Any mode change or load restarts the enable cadence from zero.
    if (mode_d != MODE_IDLE && !mode_press && !load_press &&
        tick_q != TW'(TICK_DIV - 1)) begin
      tick_d = tick_q + TW'(1);
    end
    enable_d = (mode_d != MODE_IDLE) && (tick_q == TW'(TICK_DIV - 1)) && !load_press;
    dec_d    = (mode_d == MODE_DOWN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= MODE_IDLE;
      tick_q       <= '0;
      load_q       <= 1'b0;
      enable_q     <= 1'b0;
      dec_q        <= 1'b0;
      load_value_q <= '0;
    end else begin
      mode_q       <= mode_d;
      tick_q       <= tick_d;
      load_q       <= load_d;
      enable_q     <= enable_d;
      dec_q        <= dec_d;
      load_value_q <= load_value_d;
    end
  end

  assign ctrl.load       = load_q;
  assign ctrl.enable     = enable_q;
  assign ctrl.dec        = dec_q;
  assign ctrl.load_value = load_value_q;
  assign mode            = mode_q;

endmodule

// File: tb/tb_counter_ctrl_frontend.sv
// tb/tb_counter_ctrl_frontend.sv - directed bench with a windowed behavioural model of the front-end
module tb_counter_ctrl_frontend;
  import counter_ctrl_pkg::*;

  localparam int N    = 64;
  localparam int DB   = 16;
  localparam int TD   = 4;
  localparam int HMAX = 8192;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              btn_mode = 1'b1;
  logic              btn_load = 1'b1;
  logic [N-1:0]      sw_value = 64'h0123_4567_89AB_CDEF;
  logic [MODE_W-1:0] mode;

  counter_ctrl_if #(.N(N)) ctrl_if ();

  counter_ctrl_frontend #(.N(N), .DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_load (btn_load),
    .sw_value (sw_value),
    .ctrl     (ctrl_if.master),
    .mode     (mode)
  );

  always #5 clock = ~clock;

  // Downstream up/down counter fed by the control bundle.
  logic [N-1:0] cnt_q;
  always @(posedge clock) begin
    if (reset)               cnt_q <= '0;
    else if (ctrl_if.load)   cnt_q <= ctrl_if.load_value;
    else if (ctrl_if.enable) cnt_q <= ctrl_if.dec ? cnt_q - 1 : cnt_q + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a button level flips once the last DB samples seen through the
  // two-stage synchronizer all disagree with it; its press acts one edge later.
  bit          hist [2][0:HMAX-1];
  int          m_t = 0;
  bit          m_db [2];
  bit          m_rose [2];
  int          m_mode = 0;
  int          m_t0 = 0;
  bit          m_load = 0, m_en = 0, m_dec = 0;
  logic [63:0] m_lv = '0;

  initial begin : model
    bit          raw [2];
    bit          pr [2];
    bit          all_diff;
    bit          rst;
    int          prev;
    logic [63:0] sw;
    for (int b = 0; b < 2; b++) begin
      m_db[b]   = 0;
      m_rose[b] = 0;
      for (int i = 0; i < HMAX; i++) hist[b][i] = 0;
    end
    forever begin
      @(posedge clock);
      rst    = reset;
      raw[0] = btn_mode;
      raw[1] = btn_load;
      sw     = sw_value;
      if (rst) begin
        for (int b = 0; b < 2; b++) begin
          hist[b][m_t] = 0;
          if (m_t > 0) hist[b][m_t-1] = 0;
          m_db[b]   = 0;
          m_rose[b] = 0;
        end
        m_mode = 0; m_load = 0; m_en = 0; m_dec = 0; m_lv = '0; m_t0 = m_t;
      end else begin
        for (int b = 0; b < 2; b++) begin
          pr[b]     = m_rose[b];
          m_rose[b] = 0;
          all_diff  = (m_t >= DB + 1);
          if (all_diff)
            for (int i = 2; i < DB + 2; i++)
              if (hist[b][m_t-i] == m_db[b]) all_diff = 0;
          if (all_diff) begin
            m_db[b]   = ~m_db[b];
            m_rose[b] = m_db[b];
          end
          hist[b][m_t] = raw[b];
        end
        prev = m_mode;
        if (pr[0]) m_mode = (m_mode + 1) % 3;
        m_en = (m_mode != 0) && !pr[1] &&
               ((prev == 0) ? (TD == 1) : (((m_t - m_t0) % TD) == 0));
        if (pr[0] || pr[1]) m_t0 = m_t;
        m_load = pr[1];
        if (pr[1]) m_lv = sw;
        m_dec = (m_mode == 2);
      end
      if (m_t < HMAX - 1) m_t++;
      @(negedge clock);
      check("model_mode", 64'(mode), 64'(m_mode));
      check("model_load", 64'(ctrl_if.load), 64'(m_load));
      check("model_enable", 64'(ctrl_if.enable), 64'(m_en));
      check("model_dec", 64'(ctrl_if.dec), 64'(m_dec));
      check("model_load_value", ctrl_if.load_value, m_lv);
      check("load_enable_exclusive", 64'(ctrl_if.load & ctrl_if.enable), 64'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin : stim
    int exp_m [3] = '{1, 2, 0};
    int prior;

    // Reset held with both buttons high.
    cyc(3);
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_load", 64'(ctrl_if.load), 64'd0);
    check("rst_enable", 64'(ctrl_if.enable), 64'd0);
    check("rst_dec", 64'(ctrl_if.dec), 64'd0);
    check("rst_load_value", ctrl_if.load_value, 64'd0);
    reset = 1'b0;
    cyc(10);
    btn_mode = 1'b0;
    btn_load = 1'b0;
    cyc(30);
    check("short_hold_mode", 64'(mode), 64'd0);
    check("short_hold_lv", ctrl_if.load_value, 64'd0);

    // Bouncing mode button.
    for (int i = 0; i < 20; i++) begin
      btn_mode = ~btn_mode;
      cyc(3);
    end
    btn_mode = 1'b0;
    cyc(30);
    check("bounce_mode", 64'(mode), 64'd0);
    check("bounce_enable", 64'(ctrl_if.enable), 64'd0);

    // Three clean mode presses.
    for (int k = 0; k < 3; k++) begin
      prior = (k == 0) ? 0 : exp_m[k-1];
      btn_mode = 1'b1;
      cyc(18);
      check("press_edge17_mode", 64'(mode), 64'(prior));
      cyc(1);
      check("press_edge18_mode", 64'(mode), 64'(exp_m[k]));
      check("press_edge18_dec", 64'(ctrl_if.dec), (k == 1) ? 64'd1 : 64'd0);
      if (k == 0) begin
        cyc(3);
        check("up_enable_edge21", 64'(ctrl_if.enable), 64'd0);
        cyc(1);
        check("up_enable_edge22", 64'(ctrl_if.enable), 64'd1);
        cyc(1);
        check("up_enable_edge23", 64'(ctrl_if.enable), 64'd0);
        cyc(6);
      end else begin
        cyc(11);
      end
      btn_mode = 1'b0;
      cyc(30);
    end
    check("after_three_enable", 64'(ctrl_if.enable), 64'd0);

    btn_mode = 1'b1;
    cyc(30);
    btn_mode = 1'b0;
    cyc(30);

    // Load while counting up.
    sw_value = 64'h7FFF_FFFF_FFFF_FFFF;
    btn_load = 1'b1;
    cyc(18);
    check("load_edge17", 64'(ctrl_if.load), 64'd0);
    cyc(1);
    check("load_edge18_load", 64'(ctrl_if.load), 64'd1);
    check("load_edge18_enable", 64'(ctrl_if.enable), 64'd0);
    check("load_edge18_lv", ctrl_if.load_value, 64'h7FFF_FFFF_FFFF_FFFF);
    cyc(1);
    check("load_edge19_load", 64'(ctrl_if.load), 64'd0);
    check("counter_loaded", cnt_q, 64'h7FFF_FFFF_FFFF_FFFF);
    cyc(2);
    check("load_edge21_enable", 64'(ctrl_if.enable), 64'd0);
    cyc(1);
    check("load_edge22_enable", 64'(ctrl_if.enable), 64'd1);
    cyc(1);
    check("counter_incremented", cnt_q, 64'h8000_0000_0000_0000);
    cyc(6);
    btn_load = 1'b0;
    cyc(30);

    // Simultaneous mode and load presses while in UP.
    sw_value = 64'hA5A5_5A5A_0F0F_F0F0;
    btn_mode = 1'b1;
    btn_load = 1'b1;
    cyc(19);
    check("simul_mode", 64'(mode), 64'd2);
    check("simul_dec", 64'(ctrl_if.dec), 64'd1);
    check("simul_load", 64'(ctrl_if.load), 64'd1);
    check("simul_enable", 64'(ctrl_if.enable), 64'd0);
    check("simul_lv", ctrl_if.load_value, 64'hA5A5_5A5A_0F0F_F0F0);
    cyc(11);
    btn_mode = 1'b0;
    btn_load = 1'b0;
    cyc(30);

    // Reset in the middle of a load debounce.
    sw_value = 64'hDEAD_BEEF_CAFE_F00D;
    btn_load = 1'b1;
    cyc(12);
    reset = 1'b1;
    cyc(1);
    check("midrst_mode", 64'(mode), 64'd0);
    check("midrst_lv", ctrl_if.load_value, 64'd0);
    reset = 1'b0;
    cyc(18);
    check("midrst_edge17_load", 64'(ctrl_if.load), 64'd0);
    check("midrst_edge17_lv", ctrl_if.load_value, 64'd0);
    cyc(1);
    check("midrst_edge18_load", 64'(ctrl_if.load), 64'd1);
    check("midrst_edge18_lv", ctrl_if.load_value, 64'hDEAD_BEEF_CAFE_F00D);
    btn_load = 1'b0;
    cyc(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
